// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing start-up sequence and write-through bypass.
// Reads are combinational; the array is zeroed one entry per cycle after reset before writes are accepted.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                ready,
  output logic                wr_drop
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_idx;
  logic [AW-1:0]   clr_idx_nxt;
  logic            wr_ok;
  logic [XLEN-1:0] rf [NREGS];

  // A write to register 0 is silently ignored when it is hardwired to zero.
  assign wr_ok = (state == RUN) && we && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == AW'(NREGS - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      ready   <= (state_nxt == RUN);
      if ((state == CLEAR) && we) begin
        wr_drop <= 1'b1;
      end
    end
  end

  // Array storage carries no reset; the clear sequence is the only way it is zeroed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        rf[clr_idx] <= '0;
      end else if (wr_ok) begin
        rf[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (state == RUN) begin
        if ((ZERO_R0 != 0) && (ra == '0)) begin
          rd_data[k*XLEN +: XLEN] = '0;
        end else if (wr_ok && (wr_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[k*XLEN +: XLEN] = rf[ra];
        end
      end
    end
  end

endmodule
